tmp_alert_engine: RTL

//  Parametrised TMP10x-style temperature alert engine: takes qualified signed samples, applies the

---
 rtl/tmp_alert_pkg.sv | 28 ++
 rtl/tmp_alert_if.sv | 33 +++
 rtl/tmp_fault_queue.sv | 33 +++
 rtl/tmp_alert_engine.sv | 111 +++++++++++
 4 files changed

// File: rtl/tmp_alert_pkg.sv
// Shared types and helpers for the temperature alert engine.
package tmp_alert_pkg;

  typedef enum logic [1:0] {
    CONT    = 2'd0,
    SHDN    = 2'd1,
    OS_WAIT = 2'd2
  } state_e;

  localparam logic [2:0] FQ_SAT = 3'd6;

  function automatic logic [2:0] fq_depth(input logic [1:0] f10);
    case (f10)
      2'b00:   fq_depth = 3'd1;
      2'b01:   fq_depth = 3'd2;
      2'b10:   fq_depth = 3'd4;
      default: fq_depth = 3'd6;
    endcase
  endfunction

  // Keeps the w-3+r10 MSBs of a w-bit sample; callers truncate to w bits.
  function automatic logic [31:0] res_mask(input logic [1:0] r10, input int unsigned w);
    logic [31:0] ones;
    ones     = '1;
    res_mask = (ones >> (32 - w)) & (ones << (32'd3 - 32'(r10)));
  endfunction

endpackage

// File: rtl/tmp_alert_if.sv
// Sample, threshold/config and status signals between the sample source, register logic and engine.
interface tmp_alert_if #(
  parameter int TEMP_W = 12,
  parameter int OUT_W  = 16,
  parameter int FQ_W   = 3
);
  logic              Sample_Valid;
  logic [TEMP_W-1:0] Temperature_In;
  logic [TEMP_W-1:0] T_High;
  logic [TEMP_W-1:0] T_Low;
  logic [1:0]        R10;
  logic [1:0]        F10;
  logic              POL;
  logic              TM;
  logic              SD;
  logic              OS_Start;
  logic              Alert_Clear;
  logic [OUT_W-1:0]  Data;
  logic              Data_Valid;
  logic              OS_Busy;
  logic              Alert_Active;
  logic [FQ_W-1:0]   Fault_Count;

  modport master (
    output Sample_Valid, Temperature_In, T_High, T_Low, R10, F10, POL, TM, SD, OS_Start, Alert_Clear,
    input  Data, Data_Valid, OS_Busy, Alert_Active, Fault_Count
  );

  modport slave (
    input  Sample_Valid, Temperature_In, T_High, T_Low, R10, F10, POL, TM, SD, OS_Start, Alert_Clear,
    output Data, Data_Valid, OS_Busy, Alert_Active, Fault_Count
  );
endinterface

// File: rtl/tmp_fault_queue.sv
// Saturating consecutive-hit counter; o_reach flags an accepted hit whose post-increment count meets N.
module tmp_fault_queue
  import tmp_alert_pkg::*;
#(
  parameter int FQ_W = 3
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            i_clr,
  input  logic            i_acc,
  input  logic            i_hit,
  input  logic [FQ_W-1:0] i_n,
  output logic [FQ_W-1:0] o_cnt,
  output logic            o_reach
);

  localparam logic [FQ_W-1:0] SAT = FQ_W'(FQ_SAT);

  logic [FQ_W-1:0] r_cnt;
  logic [FQ_W-1:0] w_inc;

  assign w_inc   = (r_cnt >= SAT) ? SAT : r_cnt + FQ_W'(1);
  // >= so a live drop of N below an already-saturated count still qualifies
  assign o_reach = i_acc & i_hit & (w_inc >= i_n);
  assign o_cnt   = r_cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)       r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_acc) r_cnt <= i_hit ? w_inc : '0;
  end

endmodule

// File: rtl/tmp_alert_engine.sv
// TMP10x-style alert engine: conversion-mode FSM, masked Data register, fault queues and alert latch.
module tmp_alert_engine
  import tmp_alert_pkg::*;
#(
  parameter int TEMP_W = 12,
  parameter int OUT_W  = 16,
  parameter int FQ_W   = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  tmp_alert_if.slave bus,
  output wire        Alert
);

  state_e            r_state, w_state_nxt;
  logic              w_accept, w_os_busy;
  logic [TEMP_W-1:0] w_mask, w_m;
  logic              w_over, w_under;
  logic [FQ_W-1:0]   w_n, w_over_cnt, w_under_cnt;
  logic              w_over_reach, w_under_reach;
  logic              w_trig, w_ack, w_tm_chg, w_cnt_clr;
  logic              r_active, r_dir_high, r_tm;
  logic [OUT_W-1:0]  r_data;
  logic              r_dv;

  // Power-up mode follows SD so a part held in shutdown never converts.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= bus.SD ? SHDN : CONT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CONT:    if (bus.SD) w_state_nxt = SHDN;
      SHDN:    if (!bus.SD) w_state_nxt = CONT;
               else if (bus.OS_Start) w_state_nxt = OS_WAIT;
      OS_WAIT: if (!bus.SD) w_state_nxt = CONT;
               else if (bus.Sample_Valid) w_state_nxt = SHDN;
      default: w_state_nxt = SHDN;
    endcase
  end

  always_comb begin
    w_accept  = bus.Sample_Valid && (r_state == CONT || r_state == OS_WAIT);
    w_os_busy = (r_state == OS_WAIT);
  end

  assign w_mask  = TEMP_W'(res_mask(bus.R10, TEMP_W));
  assign w_m     = bus.Temperature_In & w_mask;
  assign w_over  = $signed(w_m) >= $signed(bus.T_High);
  assign w_under = !w_over && ($signed(w_m) < $signed(bus.T_Low));
  assign w_n     = FQ_W'(fq_depth(bus.F10));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_data <= '0;
      r_dv   <= 1'b0;
    end else begin
      r_dv <= w_accept;
      if (w_accept) r_data <= OUT_W'($signed(w_m));
    end
  end

  tmp_fault_queue #(.FQ_W(FQ_W)) u_over (
    .Clk(Clk), .Rst(Rst), .i_clr(w_cnt_clr), .i_acc(w_accept), .i_hit(w_over),
    .i_n(w_n), .o_cnt(w_over_cnt), .o_reach(w_over_reach)
  );

  tmp_fault_queue #(.FQ_W(FQ_W)) u_under (
    .Clk(Clk), .Rst(Rst), .i_clr(w_cnt_clr), .i_acc(w_accept), .i_hit(w_under),
    .i_n(w_n), .o_cnt(w_under_cnt), .o_reach(w_under_reach)
  );

  // A trigger in the same cycle as a clear suppresses the clear entirely (no toggle, no counter wipe).
  assign w_tm_chg  = (bus.TM != r_tm);
  assign w_trig    = bus.TM ? (r_dir_high ? w_over_reach : w_under_reach) : w_over_reach;
  assign w_ack     = bus.TM && bus.Alert_Clear && r_active && !w_trig && !w_tm_chg;
  assign w_cnt_clr = w_tm_chg | w_ack;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_active   <= 1'b0;
      r_dir_high <= 1'b1;
      r_tm       <= bus.TM;
    end else begin
      r_tm <= bus.TM;
      if (w_tm_chg) begin
        r_dir_high <= 1'b1;
      end else if (bus.TM) begin
        if (w_trig) begin
          r_active <= 1'b1;
        end else if (w_ack) begin
          r_active   <= 1'b0;
          r_dir_high <= ~r_dir_high;
        end
      end else begin
        if (w_over_reach)       r_active <= 1'b1;
        else if (w_under_reach) r_active <= 1'b0;
      end
    end
  end

  assign bus.Data         = r_data;
  assign bus.Data_Valid   = r_dv;
  assign bus.OS_Busy      = w_os_busy;
  assign bus.Alert_Active = r_active;
  assign bus.Fault_Count  = r_active ? w_under_cnt : w_over_cnt;
  assign Alert            = (r_active ^ bus.POL) ? 1'b0 : 1'bz;

endmodule
